seq_divider: RTL and testbench

- Multi-cycle signed integer divider for the CPU execute stage. It sits beside the ALU and serves div instructions, which the single-cycle carry-lookahead adder path cannot.
- Radix-2 non-restoring algorithm: one quotient bit per clock, using an internal WIDTH+1-bit add/subtract.
- The pipeline stalls on busy and resumes when it sees data_resultRDY.

---
 rtl/seq_divider.sv | 162 ++++++++++++++++
 tb/tb_seq_divider.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Multi-cycle signed integer divider, radix-2 non-restoring,
//             one quotient bit per clock. Quotient truncates toward zero,
//             remainder takes the sign of the dividend.
//  Ports    : clock, reset          - clock, synchronous active-high reset
//             ctrl_DIV              - start request (accepted in IDLE/DONE)
//             data_operandA/B       - dividend / divisor, two's complement
//             data_result           - quotient
//             data_remainder        - remainder
//             data_exception        - divide-by-zero or overflow
//             data_resultRDY        - one-cycle valid pulse
//             busy                  - operation in flight
//  Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    c_last_count = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_most_neg   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_all_ones   = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH:0]   r_rem;      // signed partial remainder
    logic [WIDTH-1:0] r_quo;      // holds |A| initially, quotient bits shift in
    logic [WIDTH:0]   r_dvs;      // |B|, zero-extended
    logic [CW-1:0]    r_count;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_div_zero;
    logic             r_ovf;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_remainder;
    logic             r_exception;
    logic             r_rdy;
    logic             r_busy;

    // Magnitudes as unsigned WIDTH-bit values: the most-negative operand
    // negates to itself, which read unsigned is exactly 2^(WIDTH-1).
    // Together with the zero-extension into r_dvs this is the WIDTH+1-bit
    // absolute value, so no internal overflow occurs.
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_step;
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH-1:0] w_q_signed;
    logic [WIDTH-1:0] w_r_signed;

    always_comb begin
        w_abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
        w_abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

        // Shift {rem, quo} left; add or subtract the divisor by current sign.
        w_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
        w_step  = r_rem[WIDTH] ? (w_shift + r_dvs) : (w_shift - r_dvs);

        // Final correction: a negative remainder gets the divisor added back.
        // Only the low WIDTH bits matter since the corrected value is < |B|.
        w_rem_mag  = r_rem[WIDTH] ? (r_rem[WIDTH-1:0] + r_dvs[WIDTH-1:0])
                                  : r_rem[WIDTH-1:0];
        w_q_signed = (r_sign_a ^ r_sign_b) ? (~r_quo + 1'b1) : r_quo;
        w_r_signed = r_sign_a ? (~w_rem_mag + 1'b1) : w_rem_mag;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_count     <= '0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_div_zero  <= 1'b0;
            r_ovf       <= 1'b0;
            r_result    <= '0;
            r_remainder <= '0;
            r_exception <= 1'b0;
            r_rdy       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    // DONE also accepts a start, giving back-to-back operation.
                    if (ctrl_DIV) begin
                        r_sign_a   <= data_operandA[WIDTH-1];
                        r_sign_b   <= data_operandB[WIDTH-1];
                        r_div_zero <= (data_operandB == '0);
                        r_ovf      <= (data_operandA == c_most_neg) &&
                                      (data_operandB == c_all_ones);
                        r_quo      <= w_abs_a;
                        r_dvs      <= {1'b0, w_abs_b};
                        r_rem      <= '0;
                        r_count    <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_ITER;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                S_ITER: begin
                    r_rem   <= w_step;
                    r_quo   <= {r_quo[WIDTH-2:0], ~w_step[WIDTH]};
                    r_count <= r_count + CW'(1);
                    if (r_count == c_last_count) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_div_zero) begin
                        r_result    <= '0;
                        r_remainder <= '0;
                        r_exception <= 1'b1;
                    end else if (r_ovf) begin
                        r_result    <= c_most_neg;
                        r_remainder <= '0;
                        r_exception <= 1'b1;
                    end else begin
                        r_result    <= w_q_signed;
                        r_remainder <= w_r_signed;
                        r_exception <= 1'b0;
                    end
                    r_rdy   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_remainder = r_remainder;
    assign data_exception = r_exception;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Directed self-checking bench for seq_divider (WIDTH = 32):
//             latency, busy/RDY timing, signed cases, exceptions, ignored
//             starts, back-to-back start, mid-operation reset, small random set.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_divider;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits for RDY after the start edge; n = edges seen after the start edge.
    task automatic wait_rdy(output int n, output int busy_n);
        bit seen;
        n = 0;
        busy_n = 0;
        seen = 1'b0;
        while (n < 100 && !seen) begin
            @(posedge clock); #1;
            n++;
            if (data_resultRDY) seen = 1'b1;
            else if (busy) busy_n++;
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r,
                         input logic e, input string tag);
        int n;
        int busy_n;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        wait_rdy(n, busy_n);
        busy_n += 1;  // busy is already high in the cycle right after the start edge
        chk({tag, ".latency"}, 32'(n + 1), 32'd34);
        chk({tag, ".busy_cycles"}, 32'(busy_n), 32'd33);
        chk({tag, ".quotient"}, data_result, q);
        chk({tag, ".remainder"}, data_remainder, r);
        chk({tag, ".exception"}, 32'(data_exception), 32'(e));
        chk({tag, ".busy_at_rdy"}, 32'(busy), 32'd0);
        @(posedge clock); #1;
        chk({tag, ".rdy_pulse"}, 32'(data_resultRDY), 32'd0);
        chk({tag, ".hold"}, data_result, q);
    endtask

    initial begin
        int n;
        int busy_n;
        int rdy_hits;
        logic signed [31:0] ra;
        logic signed [31:0] rb;
        logic signed [31:0] rq;
        logic signed [31:0] rr;

        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset.result", data_result, 32'd0);
        chk("reset.remainder", data_remainder, 32'd0);
        chk("reset.exception", 32'(data_exception), 32'd0);
        chk("reset.rdy", 32'(data_resultRDY), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Signed quadrants
        do_op(32'd100,             32'd7,              32'd14,             32'd2,              1'b0, "pp");
        do_op(-32'sd100,           32'd7,              -32'sd14,           -32'sd2,            1'b0, "np");
        do_op(32'd100,             -32'sd7,            -32'sd14,           32'd2,              1'b0, "pn");
        do_op(-32'sd100,           -32'sd7,            32'd14,             -32'sd2,            1'b0, "nn");
        // Exceptions and boundaries
        do_op(32'd5,               32'd0,              32'd0,              32'd0,              1'b1, "div0");
        do_op(32'h8000_0000,       32'hFFFF_FFFF,      32'h8000_0000,      32'd0,              1'b1, "ovf");
        do_op(32'h8000_0000,       32'd1,              32'h8000_0000,      32'd0,              1'b0, "mneg_1");
        do_op(32'h8000_0000,       32'h8000_0000,      32'd1,              32'd0,              1'b0, "mneg_mneg");
        do_op(32'h7FFF_FFFF,       32'h8000_0000,      32'd0,              32'h7FFF_FFFF,      1'b0, "max_mneg");
        do_op(32'd7,               32'd100,            32'd0,              32'd7,              1'b0, "small");
        do_op(-32'sd1,             32'd2,              32'd0,              -32'sd1,            1'b0, "neg1_2");

        // Start ignored while busy, then back-to-back start in the RDY cycle
        @(negedge clock);
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        ctrl_DIV      = 1'b1;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        repeat (9) begin
            @(posedge clock); #1;
        end
        data_operandA = 32'd1;
        data_operandB = 32'd1;
        ctrl_DIV      = 1'b1;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        wait_rdy(n, busy_n);
        chk("ign.latency", 32'(n + 11), 32'd34);
        chk("ign.quotient", data_result, 32'd10);
        chk("ign.remainder", data_remainder, 32'd0);
        data_operandA = 32'd9;
        data_operandB = 32'd2;
        ctrl_DIV      = 1'b1;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        chk("b2b.busy", 32'(busy), 32'd1);
        chk("b2b.rdy_low", 32'(data_resultRDY), 32'd0);
        wait_rdy(n, busy_n);
        chk("b2b.latency", 32'(n + 1), 32'd34);
        chk("b2b.quotient", data_result, 32'd4);
        chk("b2b.remainder", data_remainder, 32'd1);

        // Reset mid-iteration aborts without an RDY pulse
        @(negedge clock);
        data_operandA = 32'd1000;
        data_operandB = 32'd3;
        ctrl_DIV      = 1'b1;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        repeat (14) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort.result", data_result, 32'd0);
        chk("abort.remainder", data_remainder, 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.rdy", 32'(data_resultRDY), 32'd0);
        rdy_hits = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (data_resultRDY) rdy_hits++;
        end
        chk("abort.no_rdy", 32'(rdy_hits), 32'd0);
        do_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, "restart");

        // Small random set against the language's own signed / and %
        for (int i = 0; i < 40; i++) begin
            ra = $signed($urandom);
            rb = $signed($urandom >> $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) rb = -rb;
            if (rb == 0) rb = 32'sd1;
            if (ra == 32'sh8000_0000 && rb == -32'sd1) rb = 32'sd3;
            rq = ra / rb;
            rr = ra % rb;
            do_op(ra, rb, rq, rr, 1'b0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
